// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer for the 141L 8-bit ALU and register file.
// Each instruction steps FETCH -> DECODE -> EXEC -> WB. HALT ends in DONE and is retired at EXEC.
module alu_seq_ctrl #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       instr,
  output logic [2:0]       alu_op,
  output logic [2:0]       ra_addr,
  output logic [2:0]       rb_addr,
  input  logic             taken,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_LSF  = 3'b001;
  localparam logic [2:0] OP_POS  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;

  function automatic logic [2:0] alu_sel(input logic [2:0] op);
    case (op)
      OP_LSF, OP_POS, OP_XOR, OP_BEQ: return op;
      default:                        return 3'b000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic              tkn_q, tkn_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [2:0]        ra_q, ra_d;
  logic [2:0]        rb_q, rb_d;
  logic              we_q, we_d;
  logic [2:0]        wa_q, wa_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        op, fa, fb;
  logic [CNT_W-1:0]  cnt_inc;
  logic [PC_W-1:0]   br_tgt;
  logic              is_br;

  assign op      = ir_q[8:6];
  assign fa      = ir_q[5:3];
  assign fb      = ir_q[2:0];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign br_tgt  = pc_q + {{(PC_W-3){fb[2]}}, fb};
  assign is_br   = (op == OP_POS) || (op == OP_BEQ);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    tkn_d    = tkn_q;
    alu_op_d = alu_op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    we_d     = we_q;
    wa_d     = wa_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = START_PC;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // Controls are set up as IR loads so they are stable for all of EXEC.
        ir_d     = instr;
        alu_op_d = alu_sel(instr[8:6]);
        ra_d     = instr[5:3];
        rb_d     = instr[2:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        tkn_d = taken;
        if (op == OP_HALT) begin
          state_d  = S_DONE;
          alu_op_d = 3'b000;
          cnt_d    = cnt_inc;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          state_d = S_WB;
          if ((op == OP_LSF) || (op == OP_XOR)) begin
            we_d = 1'b1;
            wa_d = fa;
          end
        end
      end
      S_WB: begin
        we_d     = 1'b0;
        alu_op_d = 3'b000;
        cnt_d    = cnt_inc;
        pc_d     = (is_br && tkn_q) ? br_tgt : pc_q + PC_W'(1);
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ir_q     <= '0;
      tkn_q    <= 1'b0;
      alu_op_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      tkn_q    <= tkn_d;
      alu_op_q <= alu_op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // A reset landing in WB must not let that cycle's write reach the register file.
  assign rf_we     = we_q & ~reset;
  assign imem_addr = pc_q;
  assign alu_op    = alu_op_q;
  assign ra_addr   = ra_q;
  assign rb_addr   = rb_q;
  assign rf_waddr  = wa_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: an instruction-level interpreter expands each program into a per-cycle
// expected trace, and a negedge compare process checks the DUT against it every cycle.
module tb_alu_seq_ctrl;
  localparam int PW = 10;
  localparam int CW = 4;
  localparam logic [8:0] NOP = 9'b010_000_000;

  logic          clk = 1'b0;
  logic          reset, start, taken;
  logic [8:0]    instr;
  logic [PW-1:0] imem_addr;
  logic [2:0]    alu_op, ra_addr, rb_addr, rf_waddr;
  logic          rf_we, busy, done;
  logic [CW-1:0] instr_cnt;

  alu_seq_ctrl #(.PC_W(PW), .START_PC('0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .instr(instr),
    .alu_op(alu_op), .ra_addr(ra_addr), .rb_addr(rb_addr), .taken(taken),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .busy(busy), .done(done), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [8:0] imem [0:1023];
  always @(posedge clk) instr <= imem[imem_addr];

  typedef struct packed {
    logic [PW-1:0] ia;
    logic [2:0]    op, ra, rb;
    logic          we;
    logic [2:0]    wa;
    logic          busy, done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t ex[$];
  bit   drvtk[$];
  bit   tkq[$];
  logic [2:0] m_ra = 0, m_rb = 0, m_wa = 0;

  int total = 0, bad = 0;
  int cur = 0;
  bit chk_en = 0;
  logic [PW-1:0] log_ia   [0:4095];
  logic          log_we   [0:4095];
  logic          log_done [0:4095];
  logic          log_busy [0:4095];
  logic [CW-1:0] log_cnt  [0:4095];
  logic [2:0]    log_wa   [0:4095];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    total++;
    if (act !== exv) begin
      bad++;
      $display("FAIL %s t=%0t cyc=%0d got=%0h want=%0h", nm, $time, cur, act, exv);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [2:0] op);
    return (op == 3'b001 || op == 3'b011 || op == 3'b100 || op == 3'b101) ? op : 3'b000;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      e = ex[cur];
      chk("imem_addr", 32'(imem_addr), 32'(e.ia));
      chk("alu_op",    32'(alu_op),    32'(e.op));
      chk("ra_addr",   32'(ra_addr),   32'(e.ra));
      chk("rb_addr",   32'(rb_addr),   32'(e.rb));
      chk("rf_we",     32'(rf_we),     32'(e.we));
      chk("rf_waddr",  32'(rf_waddr),  32'(e.wa));
      chk("busy",      32'(busy),      32'(e.busy));
      chk("done",      32'(done),      32'(e.done));
      chk("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
      log_ia[cur] = imem_addr; log_we[cur] = rf_we; log_done[cur] = done;
      log_busy[cur] = busy; log_cnt[cur] = instr_cnt; log_wa[cur] = rf_waddr;
    end
  end

  // Interpret the program at instruction level; each instruction expands into its cycle trace.
  task automatic build_trace(input int maxi, output bit halted);
    int pc, cnt, n, d;
    logic [8:0] w;
    logic [2:0] op, fa, fb;
    bit tk;
    exp_t e;
    ex.delete(); drvtk.delete();
    e = '0;
    ex.push_back(e); drvtk.push_back(1'b0);
    pc = 0; cnt = 0; n = 0; halted = 0;
    while (!halted && n < maxi) begin
      w = imem[pc]; op = w[8:6]; fa = w[5:3]; fb = w[2:0];
      tk = (tkq.size() > 0) ? tkq.pop_front() : 1'($urandom);
      e.ia = PW'(pc); e.op = 0; e.ra = m_ra; e.rb = m_rb; e.we = 0; e.wa = m_wa;
      e.busy = 1; e.done = 0; e.cnt = CW'(cnt);
      ex.push_back(e); drvtk.push_back(1'($urandom));
      ex.push_back(e); drvtk.push_back(1'($urandom));
      m_ra = fa; m_rb = fb;
      e.op = alu_of(op); e.ra = fa; e.rb = fb;
      ex.push_back(e); drvtk.push_back(tk);
      if (cnt < (2**CW - 1)) cnt++;
      if (op == 3'b000) begin
        e.op = 0; e.busy = 0; e.done = 1; e.cnt = CW'(cnt);
        ex.push_back(e); drvtk.push_back(1'($urandom));
        halted = 1;
      end else begin
        if (op == 3'b001 || op == 3'b100) begin
          e.we = 1; e.wa = fa; m_wa = fa;
        end
        ex.push_back(e); drvtk.push_back(1'($urandom));
        d = (fb >= 4) ? int'(fb) - 8 : int'(fb);
        if ((op == 3'b011 || op == 3'b101) && tk) pc = (pc + d + 1024) % 1024;
        else pc = (pc + 1) % 1024;
      end
      n++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1; start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_ra = 0; m_rb = 0; m_wa = 0;
  endtask

  // nz_all: hold start high through every busy cycle, otherwise pulse it at random.
  task automatic run_prog(input int maxi, input bit nz_all, output bit halted);
    build_trace(maxi, halted);
    @(posedge clk); #1 start = 1; taken = 1'($urandom);
    for (int c = 1; c < ex.size(); c++) begin
      @(posedge clk); #1;
      start = ex[c].busy && (nz_all || ($urandom_range(0, 3) == 0));
      taken = drvtk[c];
      cur = c; chk_en = 1;
    end
    @(negedge clk); #1 chk_en = 0; start = 0;
    if (!halted) do_reset();
  endtask

  task automatic clr_mem();
    for (int a = 0; a < 1024; a++) imem[a] = NOP;
  endtask

  initial begin
    bit h;
    reset = 1; start = 0; taken = 0;
    clr_mem();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_imem_addr", 32'(imem_addr), 0); chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_ra", 32'(ra_addr), 0); chk("rst_rb", 32'(rb_addr), 0);
      chk("rst_we", 32'(rf_we), 0); chk("rst_wa", 32'(rf_waddr), 0);
      chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
      chk("rst_cnt", 32'(instr_cnt), 0);
    end

    // XOR r1,r2 ; HALT with start held high while busy
    imem[0] = 9'b100_001_010; imem[1] = 9'b000_000_000;
    run_prog(10, 1'b1, h);
    for (int c = 1; c <= 8; c++) chk("xor_we_cycle", 32'(log_we[c]), (c == 4) ? 1 : 0);
    chk("xor_waddr", 32'(log_wa[4]), 1);
    chk("xor_done7", 32'(log_done[7]), 0);
    chk("xor_done8", 32'(log_done[8]), 1);
    chk("xor_cnt", 32'(log_cnt[8]), 2);
    chk("xor_busy", 32'(log_busy[8]), 0);

    // BEQ r3,-2 at PC 5, taken then not taken; restarts from DONE
    clr_mem();
    imem[5] = 9'b101_011_110; imem[6] = 9'b000_000_000;
    tkq = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    run_prog(20, 1'b0, h);
    chk("restart_done", 32'(log_done[1]), 0);
    chk("restart_pc", 32'(log_ia[1]), 0);
    chk("restart_cnt", 32'(log_cnt[1]), 0);
    chk("beq_taken_pc", 32'(log_ia[25]), 3);
    chk("beq_nt_pc", 32'(log_ia[37]), 6);
    chk("beq_halted", 32'(h), 1);

    // PC wrap both ways
    clr_mem();
    imem[0] = 9'b101_000_111; imem[1] = 9'b101_000_101;
    imem[1022] = 9'b011_000_011; imem[2] = 9'b000_000_000;
    tkq = '{1, 0, 0, 1, 1, 0, 0};
    run_prog(20, 1'b0, h);
    chk("wrap_back", 32'(log_ia[5]), 1023);
    chk("wrap_fwd", 32'(log_ia[9]), 0);
    chk("wrap_b1", 32'(log_ia[13]), 1);
    chk("wrap_b2", 32'(log_ia[17]), 1022);
    chk("wrap_pos", 32'(log_ia[21]), 1);
    chk("wrap_end", 32'(log_ia[25]), 2);

    // counter saturation: 20 NOPs then HALT
    clr_mem();
    imem[20] = 9'b000_000_000;
    run_prog(30, 1'b0, h);
    chk("sat_cnt", 32'(instr_cnt), 15);

    // reset during WB of an XOR
    clr_mem();
    imem[0] = 9'b100_001_010; imem[1] = 9'b000_000_000;
    @(posedge clk); #1 start = 1;
    repeat (3) begin @(posedge clk); #1 start = 0; end
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("rstwb_we", 32'(rf_we), 0);
    chk("rstwb_busy", 32'(busy), 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rstwb_busy_after", 32'(busy), 0);
    chk("rstwb_cnt", 32'(instr_cnt), 0);
    chk("rstwb_done", 32'(done), 0);
    chk("rstwb_wa", 32'(rf_waddr), 0);
    chk("rstwb_pc", 32'(imem_addr), 0);
    m_ra = 0; m_rb = 0; m_wa = 0;

    // random programs
    for (int r = 0; r < 25; r++) begin
      logic [2:0] op;
      for (int a = 0; a < 1024; a++) begin
        op = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 9) == 0) op = 3'b000;
        imem[a] = {op, 6'($urandom)};
      end
      run_prog(60, 1'b0, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM that sequences the 8-bit ALU and register file of the 141L core.
- Fetches 9-bit instructions from synchronous instruction memory and decodes them.
- Per instruction: drives alu_op and register-file read/write controls, and resolves branches from the ALU's taken flag.
- Runs from a start pulse until a HALT instruction, then raises done.

Parameters:
- PC_W, 10, program counter / imem address width.
- START_PC, 0, PC loaded on each start.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin program execution; sampled in IDLE and DONE only
- imem_addr  out  PC_W  instruction memory address (= current PC)
- instr  in  9  imem read data; valid the cycle after imem_addr is presented
- alu_op  out  3  ALU operation select
- ra_addr  out  3  register-file read port A (ALU inA)
- rb_addr  out  3  register-file read port B (ALU inB)
- taken  in  1  ALU branch-condition output (combinational)
- rf_we  out  1  register-file write enable; write data is ALU rslt
- rf_waddr  out  3  register-file write address
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- done  out  1  high in DONE
- instr_cnt  out  CNT_W  retired instructions since last start

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Instruction fields: op = instr[8:6], fa = instr[5:3], fb = instr[2:0].
- Opcodes:
  - 000 HALT.
  - 001 LSF: R[fa] <= alu(R[fa], R[fb]).
  - 011 POS: if R[fa] > 0, PC <= PC + sext(fb).
  - 100 XOR: R[fa] <= R[fa] ^ R[fb].
  - 101 BEQ: if R[fa] == 0, PC <= PC + sext(fb).
  - 010, 110, 111: NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE. Reset value is IDLE.
- Reset values: alu_op=0, ra_addr=0, rb_addr=0, rf_we=0, rf_waddr=0, busy=0, done=0, instr_cnt=0, PC=START_PC, imem_addr=START_PC.
- IDLE: start=1 -> PC <= START_PC, instr_cnt <= 0, go to FETCH.
- FETCH: imem_addr = PC. Go to DECODE.
- DECODE: latch instr into IR. Go to EXEC.
- EXEC:
  - alu_op = IR.op for 001/011/100/101, else 000.
  - ra_addr = IR.fa, rb_addr = IR.fb.
  - taken is sampled at the end of this cycle.
  - HALT -> DONE; instr_cnt increments (HALT counts as retired).
  - All other ops -> WB.
- WB:
  - alu_op, ra_addr, rb_addr held from EXEC, so rslt stays valid.
  - rf_we = 1 for exactly this cycle for LSF/XOR, with rf_waddr = IR.fa; rf_we = 0 otherwise.
  - PC update: PC + sext(fb) if POS/BEQ and sampled taken=1, else PC + 1.
  - instr_cnt increments.
  - Go to FETCH.
- DONE: done=1, PC frozen. start=1 restarts exactly as from IDLE (done drops the next cycle).
- Latency: 4 cycles per non-HALT instruction. HALT retires in 3 cycles (FETCH, DECODE, EXEC).
- Outside EXEC/WB: alu_op=0, rf_we=0. ra_addr, rb_addr and rf_waddr hold their last values.
- PC arithmetic is modulo 2^PC_W:
  - 2^PC_W-1 + 1 wraps to 0.
  - sext(fb) ranges -4..+3; fb=0 branches to self.
- instr_cnt saturates at 2^CNT_W-1 (no wrap).
- start while busy is ignored; it never restarts mid-program.
- reset in any state, including mid-WB, returns to IDLE with reset values. Any rf_we in that cycle is suppressed.

Test Plan:
- Reset held 2 cycles then released with start=0 -> IDLE, all outputs 0, imem_addr=0, stays idle.
- Program [XOR r1,r2 (100_001_010); HALT] with start pulse:
  - rf_we=1 with rf_waddr=1 in cycle 4 only.
  - done=1 at cycle 8.
  - instr_cnt=2, busy=0.
- BEQ r3,-2 at PC=5 (101_011_110):
  - taken=1 -> next imem_addr=3.
  - taken=0 -> next imem_addr=6.
  - rf_we stays 0.
- PC=1023 with NOP, PC_W=10 -> next fetch at imem_addr=0; POS r0,+3 at PC=1022 with taken=1 -> imem_addr=1.
- start asserted during EXEC -> ignored, sequence unchanged.
- start in DONE -> restart at PC=0, counter cleared.
- reset asserted in WB of an XOR -> no rf_we that cycle, state IDLE, instr_cnt=0.
